// File: rtl/afifo_pkg.sv
// Shared types and constants for the asynchronous FIFO write-side logic.
// Included by the round-robin picker and the write-port arbiter.
package afifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int AFIFO_DW    = 4;
  localparam int AFIFO_DEPTH = 16;

  // Index width for an N-way selector; a 1-way selector still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afifo_rr_pick.sv
// Cyclic first-set search: returns the first requester at or after ptr,
// wrapping from N-1 back to 0.
module afifo_rr_pick
  import afifo_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] rot;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % N;
    return s[IW-1:0];
  endfunction

  // rot[k] is the request k positions after ptr.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot[gi] = req[wrap_add(ptr, gi)];
  end

  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = wrap_add(ptr, k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-based sharer of the async FIFO write port. fifo_full
// gates every write, so this block alone keeps the FIFO from overflowing.
module afifo_wr_arbiter
  import afifo_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = AFIFO_DW,
  parameter int BURST_LEN = 4,
  localparam int IW = idx_w(N),
  localparam int CW = $clog2(BURST_LEN) + 1
) (
  input  logic            wclk,
  input  logic            wrstn,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data_flat,
  output logic [N-1:0]    gnt,
  input  logic            fifo_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_data,
  output logic [IW-1:0]   owner,
  output logic            busy
);

  arb_state_t    state_reg;
  logic [IW-1:0] owner_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [CW-1:0] beat_cnt_reg;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_req;
  logic          acc;
  logic          last_beat;
  logic [DW-1:0] data_arr [N];

  afifo_rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_data
    assign data_arr[gi] = data_flat[gi*DW +: DW];
  end

  assign owner_req = req[owner_reg];
  assign acc       = (state_reg == BURST) && owner_req && !fifo_full;
  assign last_beat = (beat_cnt_reg == CW'(BURST_LEN - 1));
  assign ptr_next  = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = acc && (owner_reg == IW'(gi));
  end

  assign fifo_wr_en = acc;
  assign fifo_data  = acc ? data_arr[owner_reg] : '0;
  assign owner      = owner_reg;
  assign busy       = (state_reg == BURST);

  // A dropped owner request releases the port even while full is high;
  // a full stall holds the count and keeps the grant with no timeout.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            state_reg    <= BURST;
            owner_reg    <= pick_idx;
            beat_cnt_reg <= '0;
          end
        end
        BURST: begin
          if (!owner_req) begin
            state_reg <= IDLE;
            ptr_reg   <= ptr_next;
          end else if (acc) begin
            if (last_beat) begin
              state_reg    <= IDLE;
              ptr_reg      <= ptr_next;
              beat_cnt_reg <= '0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter: a table-driven single burst,
// hand-written corner sequences and a randomized run against a behavioural model.
module tb_afifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BL = 4;

  logic            wclk = 1'b0;
  logic            wrstn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data_flat = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    gnt;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic [1:0]      owner;
  logic            busy;

  afifo_wr_arbiter #(.N(N), .DW(DW), .BURST_LEN(BL)) dut (
    .wclk       (wclk),
    .wrstn      (wrstn),
    .req        (req),
    .data_flat  (data_flat),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_count = 0;
  int wr_by [N];
  int own_q [$];

  // Behavioural model: who holds the port, where the search starts, beats done.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_beats;

  typedef struct {
    logic [N-1:0]  req;
    logic [DW-1:0] d2;
    logic          full;
    logic [N-1:0]  gnt;
    logic          wr;
    logic [DW-1:0] data;
    logic [1:0]    owner;
    logic          busy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int rr_search(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
  endtask

  task automatic model_release();
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % N;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic f);
    int p;
    if (!m_busy) begin
      p = rr_search(r, m_ptr);
      if (p >= 0) begin
        m_busy = 1'b1; m_owner = p; m_beats = 0;
      end
    end else if (!r[m_owner]) begin
      model_release();
    end else if (!f) begin
      m_beats++;
      if (m_beats == BL) model_release();
    end
  endtask

  task automatic log_write();
    if (fifo_wr_en) begin
      wr_count++;
      wr_by[owner]++;
      if (own_q.size() == 0 || own_q[$] != int'(owner)) own_q.push_back(int'(owner));
      $display("WR cyc=%0d owner=%0d data=%h full=%b", cyc, owner, fifo_data, fifo_full);
    end
  endtask

  task automatic clear_stats();
    wr_count = 0;
    own_q.delete();
    for (int i = 0; i < N; i++) wr_by[i] = 0;
  endtask

  // Drive one cycle, compare against the model mid-cycle, advance the model at the edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic f);
    logic          ea;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    req = r; data_flat = d; fifo_full = f;
    @(negedge wclk);
    ea = m_busy && r[m_owner] && !f;
    eg = '0;
    if (ea) eg[m_owner] = 1'b1;
    ed = ea ? d[m_owner*DW +: DW] : '0;
    chk("gnt", gnt, eg);
    chk("wr_en", fifo_wr_en, ea);
    chk("data", fifo_data, ed);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_busy);
    chk("no_wr_when_full", fifo_wr_en & fifo_full, 0);
    log_write();
    @(posedge wclk);
    model_step(r, f);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    wrstn = 1'b0; req = '0; data_flat = '0; fifo_full = 1'b0;
    @(posedge wclk); #1;
    chk("reset_outputs", {gnt, fifo_wr_en, fifo_data, owner, busy}, 0);
    @(posedge wclk); #1;
    wrstn = 1'b1;
    model_reset();
    clear_stats();
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [31:0] u;
    u = $urandom;
    return u[N*DW-1:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    r;
    int              exp_own [4];

    // Single burst on requester 2: bubble, A..D, bubble, E, release.
    vecs[0] = '{4'b0100, 4'hA, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0};
    vecs[1] = '{4'b0100, 4'hA, 1'b0, 4'b0100, 1'b1, 4'hA, 2'd2, 1'b1};
    vecs[2] = '{4'b0100, 4'hB, 1'b0, 4'b0100, 1'b1, 4'hB, 2'd2, 1'b1};
    vecs[3] = '{4'b0100, 4'hC, 1'b0, 4'b0100, 1'b1, 4'hC, 2'd2, 1'b1};
    vecs[4] = '{4'b0100, 4'hD, 1'b0, 4'b0100, 1'b1, 4'hD, 2'd2, 1'b1};
    vecs[5] = '{4'b0100, 4'hE, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd2, 1'b0};
    vecs[6] = '{4'b0100, 4'hE, 1'b0, 4'b0100, 1'b1, 4'hE, 2'd2, 1'b1};
    vecs[7] = '{4'b0000, 4'h0, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd2, 1'b1};
    vecs[8] = '{4'b0000, 4'h0, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd2, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      req = vecs[i].req; data_flat = {4'h7, vecs[i].d2, 4'h3, 4'h1}; fifo_full = vecs[i].full;
      @(negedge wclk);
      chk("tbl_gnt", gnt, vecs[i].gnt);
      chk("tbl_wr_en", fifo_wr_en, vecs[i].wr);
      chk("tbl_data", fifo_data, vecs[i].data);
      chk("tbl_owner", owner, vecs[i].owner);
      chk("tbl_busy", busy, vecs[i].busy);
      log_write();
      @(posedge wclk);
      model_step(vecs[i].req, vecs[i].full);
      cyc++;
      #1;
    end
    chk("tbl_ptr_after_burst", dut.ptr_reg, 3);

    // Round-robin between requesters 0 and 3.
    do_reset();
    repeat (20) cycle(4'b1001, rnd_data(), 1'b0);
    exp_own = '{0, 3, 0, 3};
    chk("rr_writes", wr_count, 16);
    chk("rr_bursts", own_q.size(), 4);
    for (int i = 0; i < 4 && i < own_q.size(); i++) chk("rr_owner_order", own_q[i], exp_own[i]);

    // Full stall for 3 cycles on the second beat.
    do_reset();
    d = rnd_data();
    cycle(4'b0001, d, 1'b0);
    cycle(4'b0001, d, 1'b0);
    cycle(4'b0001, d, 1'b1);
    chk("stall_cnt_hold", dut.beat_cnt_reg, 1);
    cycle(4'b0001, d, 1'b1);
    cycle(4'b0001, d, 1'b1);
    chk("stall_cnt_hold_end", dut.beat_cnt_reg, 1);
    repeat (3) cycle(4'b0001, rnd_data(), 1'b0);
    repeat (2) cycle(4'b0000, rnd_data(), 1'b0);
    chk("stall_writes", wr_count, 4);

    // Early release by requester 1 after two beats; pending 3 goes next.
    do_reset();
    repeat (3) cycle(4'b1010, rnd_data(), 1'b0);
    cycle(4'b1000, rnd_data(), 1'b0);
    cycle(4'b1000, rnd_data(), 1'b0);
    cycle(4'b1000, rnd_data(), 1'b0);
    cycle(4'b0000, rnd_data(), 1'b0);
    chk("early_writes_r1", wr_by[1], 2);
    chk("early_bursts", own_q.size(), 2);
    if (own_q.size() == 2) chk("early_next_owner", own_q[1], 3);

    // Reset asserted mid-burst, then arbitration restarts from ptr 0.
    do_reset();
    cycle(4'b0010, rnd_data(), 1'b0);
    cycle(4'b0010, rnd_data(), 1'b0);
    cycle(4'b0000, rnd_data(), 1'b0);
    cycle(4'b1000, rnd_data(), 1'b0);
    cycle(4'b1000, rnd_data(), 1'b0);
    #2;
    chk("pre_reset_gnt", gnt, 4'b1000);
    wrstn = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_wr_en", fifo_wr_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_owner", owner, 0);
    model_reset();
    @(posedge wclk); #1;
    wrstn = 1'b1;
    clear_stats();
    cycle(4'b1010, rnd_data(), 1'b0);
    cycle(4'b1010, rnd_data(), 1'b0);
    chk("rst_restart_owner", (own_q.size() > 0) ? own_q[0] : -1, 1);
    repeat (2) cycle(4'b0000, rnd_data(), 1'b0);

    // Overflow guard: 16-deep FIFO with no reads, full registered after the write.
    do_reset();
    repeat (40) cycle(4'b0100, rnd_data(), wr_count >= 16);
    chk("overflow_writes", wr_count, 16);

    // Randomized traffic with random full.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(3, 0) != 0);
      cycle(r, rnd_data(), $urandom_range(4, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arbiter.md
# afifo_wr_arbiter

Write-side arbiter that shares the single write port of the 16×4 asynchronous FIFO between `N` requesters in the write clock domain. Grants are round-robin. An owner keeps the port for a burst of up to `BURST_LEN` beats. Write enable is gated by the FIFO's registered `full` flag. The FIFO does not qualify its write pointer with `full`, so this block is the only thing that prevents overflow.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `DW`, 4, data width; must match the FIFO `data_in` width
- `BURST_LEN`, 4, maximum beats per grant (1..16)

Ports:
- `wclk` input 1: write-domain clock; all logic on its rising edge.
- `wrstn` input 1: reset, asynchronous and active-low.
- `req` input N: `req[i]` high means requester i has a beat on `data_flat`.
- `data_flat` input N*DW: requester i data in bits `[i*DW +: DW]`.
- `gnt` output N: `gnt[i]` high means requester i's beat is written this cycle (combinational).
- `fifo_full` input 1: FIFO `full` output.
- `fifo_wr_en` output 1: drives FIFO `wr_en`.
- `fifo_data` output DW: drives FIFO `data_in`.
- `owner` output clog2(N): current or last owner index.
- `busy` output 1: high while in BURST.

## Operation
- Two states:
  - IDLE: no owner.
  - BURST: owner holds the port.
- Registered state:
  - `state`
  - `owner`
  - `ptr` (round-robin start index)
  - `beat_cnt` (width clog2(BURST_LEN)+1)
- IDLE → BURST when `|req`.
  - `owner` becomes the first i with `req[i]`, scanning cyclically from `ptr`.
  - `beat_cnt` ← 0.
- Beat accept (combinational): `acc = (state==BURST) & req[owner] & ~fifo_full`.
  - `fifo_wr_en = acc`.
  - `gnt = acc ? (1<<owner) : 0`.
  - `fifo_data = acc ? owner's data : 0`.
- In BURST, on an accepted beat, `beat_cnt` increments.
  - If `beat_cnt == BURST_LEN-1`, go to IDLE and set `ptr ← (owner+1) mod N`.
- In BURST with `req[owner]==0`: no beat; go to IDLE and set `ptr ← (owner+1) mod N`.
- In BURST with `req[owner]==1` and `fifo_full==1`: stall.
  - No beat is written and the count is held.
  - The owner keeps the grant indefinitely; there is no timeout.
- Requesters on `gnt`:
  - Present the next beat on the following cycle, or drop `req`.
  - Must hold data stable while `req` is high and `gnt` is low.
- `fifo_wr_en` is never high in a cycle where `fifo_full` is high.
- Requests from non-owners are ignored until the burst ends.

## Timing
- Reset values (asynchronous, on `wrstn` low):
  - state IDLE, `owner` 0, `ptr` 0, `beat_cnt` 0.
  - Hence `gnt` 0, `fifo_wr_en` 0, `fifo_data` 0, `busy` 0.
- Arbitration latency:
  - `req` seen in IDLE at edge k; the first beat can be written in cycle k+1.
  - There is one IDLE bubble cycle between consecutive bursts.
- Minimum burst occupancy is BURST_LEN+1 cycles per grant, including the bubble.
- `fifo_full` is used as sampled. It is registered in the FIFO, so it rises in the cycle after the 16th outstanding write, and the gating above is exact.
- `ptr` wraps from N-1 to 0.
- `beat_cnt` never exceeds BURST_LEN-1.
- Reset asserted mid-burst:
  - The burst is abandoned immediately and all outputs go to their reset values.
  - Beats already written stay in the FIFO.
- Full rising and `req[owner]` dropping in the same cycle: the drop wins, so there is no beat and the block releases to IDLE.

## Structure
- Package `afifo_pkg`:
  - `arb_state_t` enum {IDLE, BURST}.
  - `AFIFO_DW = 4`.
  - `AFIFO_DEPTH = 16`.
- Sub-module `afifo_rr_pick`: purely combinational.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `idx`, `any`.
  - Implements the cyclic first-set search.
- The top module holds the FSM, the counters and the data mux.

## Test plan
- **Single burst:** N=4, BURST_LEN=4; `req[2]` held with data 0xA,0xB,0xC,0xD,0xE.
  - One IDLE cycle, then 4 consecutive `gnt[2]`/`fifo_wr_en` pulses writing 0xA..0xD.
  - Then return to IDLE, `ptr`=3, and the next grant (0xE) follows after one bubble.
- **Round-robin:** `req[0]` and `req[3]` both continuous from reset.
  - Owners in order 0,3,0,3, each for 4 beats.
  - `ptr` wraps 0→1 and 3→0.
- **Full stall:** `fifo_full` forced high for 3 cycles during beat 2.
  - `fifo_wr_en` low for exactly those cycles, `beat_cnt` holds at 1.
  - The burst completes with 4 total writes.
- **Early release:** `req[1]` dropped after 2 accepted beats.
  - Exactly 2 writes, IDLE next cycle, `ptr`=2.
  - A pending `req[3]` is granted next.
- **Reset mid-burst:** `wrstn` pulled low after beat 1.
  - `gnt`, `fifo_wr_en` and `busy` go to 0 asynchronously, within the same cycle.
  - After release, arbitration restarts from `ptr`=0.
- **Overflow guard:** one requester streams 20 beats into the FIFO with the read side idle.
  - Exactly 16 writes occur.
  - `fifo_wr_en` is never high while `fifo_full` is high.
